rr_arbiter_8_to_3: RTL

Round-robin arbiter that shares a single downstream resource among eight requesters. It issues a registered one-hot grant and its 3-bit encoded index, holds each grant for a full tenure, and rotates priority on every release. The block sits in front of any resource addressed by a 3-bit select. It reuses the team's 8-to-3 encoder to produce the index.

---
 rtl/rr_arb_pkg.sv | 30 +++
 rtl/encoder_8_to_3.sv | 16 +
 rtl/rr_arbiter_8_to_3.sv | 98 +++++++++
 3 files changed

// File: rtl/rr_arb_pkg.sv
// Shared types and the rotated-priority pick for the 8-requester round-robin arbiter.
package rr_arb_pkg;

  localparam int unsigned N_REQ = 8;
  localparam int unsigned IDX_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // One-hot pick of the first set request at or above ptr, wrapping 7 -> 0.
  function automatic logic [N_REQ-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                               input logic [IDX_W-1:0] ptr);
    logic [N_REQ-1:0] pick;
    logic [IDX_W-1:0] idx;
    logic             found;
    pick  = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = ptr + IDX_W'(k);
      if (!found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/encoder_8_to_3.sv
// One-hot to binary encoder; all-zero input encodes to 0.
module encoder_8_to_3
  import rr_arb_pkg::*;
(
  input  logic [N_REQ-1:0] onehot,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    idx = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (onehot[i]) idx = idx | IDX_W'(i);
    end
  end

endmodule

// File: rtl/rr_arbiter_8_to_3.sv
// Round-robin arbiter, 8 requesters, one registered grant per tenure.
// Optional forced release after HOLD_MAX cycles when RR_ARB_TIMEOUT_EN is defined.
module rr_arbiter_8_to_3
  import rr_arb_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid,
  output logic             timeout
);

  if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_hold_max
    $error("rr_arbiter_8_to_3: HOLD_MAX must be in 2..255");
  end

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic             owner_req;
  logic             to_fire;
  logic             rel;

  encoder_8_to_3 u_enc (
    .onehot (grant),
    .idx    (grant_idx)
  );

`ifdef RR_ARB_TIMEOUT_EN
  logic [7:0] hold_cnt;
`endif

  // Release decision for the current tenure; all causes merge into one release.
  always_comb begin
    owner_req = |(req & grant);
`ifdef RR_ARB_TIMEOUT_EN
    to_fire   = (hold_cnt == 8'(HOLD_MAX - 1));
`else
    to_fire   = 1'b0;
`endif
    rel       = done | ~owner_req | to_fire;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      grant       <= '0;
      grant_valid <= 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
      hold_cnt    <= '0;
      timeout     <= 1'b0;
`endif
    end else begin
`ifdef RR_ARB_TIMEOUT_EN
      timeout <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (|req) begin
            grant       <= rr_pick(req, ptr);
            grant_valid <= 1'b1;
            state       <= BUSY;
`ifdef RR_ARB_TIMEOUT_EN
            hold_cnt    <= '0;
`endif
          end
        end
        BUSY: begin
          if (rel) begin
            ptr         <= grant_idx + IDX_W'(1);
            grant       <= '0;
            grant_valid <= 1'b0;
            state       <= IDLE;
`ifdef RR_ARB_TIMEOUT_EN
            // Flag only a release that the counter alone caused.
            timeout     <= to_fire & ~done & owner_req;
`endif
          end else begin
`ifdef RR_ARB_TIMEOUT_EN
            hold_cnt    <= hold_cnt + 8'd1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef RR_ARB_TIMEOUT_EN
  assign timeout = 1'b0;
`endif

endmodule
